operand_bus_arbiter: RTL and testbench
======================================

// Module: operand_bus_arbiter
// PURPOSE
//  Shares one 32-bit datapath mux (Mux_32) between two requesters feeding a common result bus.
//  Round-robin FSM with a bounded hold per grant drives the mux select (op) and registers the
//  selected word into a one-deep output stage with valid/ready handshake on both sides.
//  Sits between two producers (e.g. ALU result, load data) and the write-back consumer.
// PARAMETERS
//  WIDTH     32  data width of requester and output buses
//  MAX_HOLD  4   max consecutive accepted beats per grant while the other side is waiting (>=1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  req0_valid  in   1      requester 0 has a word (routed to Mux_32 input1)
//  req0_data   in   WIDTH  requester 0 word
//  req0_ready  out  1      requester 0 beat accepted this cycle when req0_valid=1
//  req1_valid  in   1      requester 1 has a word (routed to Mux_32 input2)
//  req1_data   in   WIDTH  requester 1 word
//  req1_ready  out  1      requester 1 beat accepted this cycle when req1_valid=1
//  mux_op      out  1      select to Mux_32: 0=req0, 1=req1
//  grant       out  2      one-hot current owner; 2'b00 in IDLE
//  out_valid   out  1      out_data holds a word
//  out_data    out  WIDTH  registered mux output
//  out_ready   in   1      consumer takes out_data this cycle when out_valid=1
// BEHAVIOUR
//  Reset (async, immediate, no clock needed): state=IDLE, grant=00, mux_op=0, out_valid=0,
//   out_data=0, hold count=0, last_owner=1 (so req0 wins the first tie). req*_ready=0.
//  FSM states IDLE, GNT0, GNT1; grant/mux_op are registered from the state (GNT1 -> op=1, else 0).
//  IDLE: req0_valid & req1_valid -> grant to the side != last_owner; one valid -> that side;
//   none -> stay. No beat transfers in IDLE.
//  GNTx: req_x_ready = (!out_valid | out_ready), combinational; other side ready=0.
//   Beat = req_x_valid & req_x_ready; on beat out_data <= req_x_data via Mux_32, out_valid <= 1,
//   count <= count+1. Latency: word visible on out_data the cycle after acceptance.
//  Leaving GNTx (evaluated each cycle, last_owner <= x on exit):
//   - req_x_valid=0: other valid -> GNT(other), else IDLE; count <= 0.
//   - beat with count==MAX_HOLD-1: other valid -> GNT(other), count <= 0;
//     other idle -> stay in GNTx, count <= 0.
//   - otherwise stay.
//  Switch cycle: direct GNT0<->GNT1 transitions take one edge; no beat from the new owner
//   until grant shows it. No beat is ever accepted from a non-granted side.
//  Output stage: out_valid & !out_ready -> out_data and out_valid held, ready of owner=0,
//   count not advanced. out_ready & !new beat -> out_valid <= 0 (out_data keeps last value).
//   out_ready & new beat in same cycle -> out_data replaced, out_valid stays 1 (full throughput).
//  Count width = clog2(MAX_HOLD)+1; never exceeds MAX_HOLD-1. MAX_HOLD=1 alternates every beat.
//  Reset mid-burst: in-flight out_data word discarded; after release FSM restarts from IDLE.
// TESTING
//  1 rst_n=0 (no clk edge) mid-traffic -> out_valid=0, out_data=0, grant=00, mux_op=0, readies 0.
//  2 req0_valid=1, data=34, out_ready=1 -> grant=01 next edge, req0_ready=1, out_data=34 with
//    out_valid=1 one cycle after acceptance, mux_op=0.
//  3 both valid continuously, req0=34, req1=61, out_ready=1, MAX_HOLD=4 -> out_data sequence
//    34,34,34,34,61,61,61,61,34...; mux_op toggles each switch; one bubble cycle per switch.
//  4 out_ready=0 while out_valid=1 -> out_data stays 34, req0_ready=0, count frozen; release
//    out_ready -> sequence resumes with no word lost or duplicated.
//  5 both asserted first time after reset -> req0 granted; req1 alone later, then both again from
//    IDLE with last_owner=1 -> req0 granted; with last_owner=0 -> req1 granted.
//  6 only req1 valid for 10 beats, MAX_HOLD=4 -> grant stays 10, count wraps, no gap in out_valid.

Source files
------------

// File: rtl/operand_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 32-bit mux, with a bounded
// hold per grant and a one-deep registered output stage (valid/ready on both sides).
module operand_bus_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             mux_op,
  output logic [1:0]       grant,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned      CNT_W     = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             mux_op_q, mux_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_owner_q, last_owner_d;

  logic             out_free_c;
  logic             beat_c;
  logic             owner_c;
  logic             own_valid_c;
  logic             oth_valid_c;
  logic [WIDTH-1:0] mux_data_c;

  // Owner handshake: only the side the registered grant already shows may transfer.
  always_comb begin
    out_free_c = !out_valid_q || out_ready;
    req0_ready = (state_q == GNT0) && grant_q[0] && out_free_c;
    req1_ready = (state_q == GNT1) && grant_q[1] && out_free_c;
    beat_c     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    mux_data_c = mux_op_q ? req1_data : req0_data;
  end

  // Next-state: round-robin arbitration with a bounded number of beats per grant.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_owner_d = last_owner_q;
    owner_c      = (state_q == GNT1);
    own_valid_c  = owner_c ? req1_valid : req0_valid;
    oth_valid_c  = owner_c ? req0_valid : req1_valid;
    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          state_d = last_owner_q ? GNT0 : GNT1;
        end else if (req0_valid) begin
          state_d = GNT0;
        end else if (req1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!own_valid_c) begin
          count_d      = '0;
          last_owner_d = owner_c;
          state_d      = oth_valid_c ? (owner_c ? GNT0 : GNT1) : IDLE;
        end else if (beat_c) begin
          if (count_q == HOLD_LAST) begin
            count_d = '0;
            if (oth_valid_c) begin
              state_d      = owner_c ? GNT0 : GNT1;
              last_owner_d = owner_c;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant/select follow the state register; output stage loads on a beat, drains on ready.
  always_comb begin
    grant_d     = 2'b00;
    mux_op_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      GNT0:    grant_d = 2'b01;
      GNT1: begin
        grant_d  = 2'b10;
        mux_op_d = 1'b1;
      end
      default: grant_d = 2'b00;
    endcase
    if (beat_c) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      mux_op_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      count_q      <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mux_op_q     <= mux_op_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      count_q      <= count_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign grant     = grant_q;
  assign mux_op    = mux_op_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Bench for operand_bus_arbiter: directed scenarios plus randomized traffic against a
// FIFO scoreboard and handshake/fairness rules.
module tb_operand_bus_arbiter;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             mux_op;
  logic [1:0]       grant;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  operand_bus_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .mux_op(mux_op), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Requester/consumer behaviour knobs.
  int               rem0, rem1;
  logic             fix0, fix1;
  logic [WIDTH-1:0] val0, val1;
  logic             rnd_gap;
  int               ordy_mode;

  // Observation state.
  logic             b0, b1, xfer_seen, prev_stall;
  logic [WIDTH-1:0] xfer_data, prev_data;
  logic [WIDTH-1:0] exp_q[$];
  int               wait0, wait1;
  logic             seq_en;
  int               k, bubbles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mux_op", 32'(mux_op), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
  endtask

  task automatic clear_obs();
    b0 = 1'b0; b1 = 1'b0; xfer_seen = 1'b0; prev_stall = 1'b0;
    wait0 = 0; wait1 = 0;
    exp_q.delete();
  endtask

  task automatic drive();
    if (b0) rem0--;
    if (b1) rem1--;
    if (b0 || !req0_valid) begin
      if (rem0 > 0 && (!rnd_gap || $urandom_range(3, 0) != 0)) begin
        req0_valid = 1'b1;
        req0_data  = fix0 ? val0 : $urandom();
      end else begin
        req0_valid = 1'b0;
      end
    end
    if (b1 || !req1_valid) begin
      if (rem1 > 0 && (!rnd_gap || $urandom_range(3, 0) != 0)) begin
        req1_valid = 1'b1;
        req1_data  = fix1 ? val1 : $urandom();
      end else begin
        req1_valid = 1'b0;
      end
    end
    case (ordy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(1, 0));
    endcase
  endtask

  task automatic sample();
    b0        = req0_valid && req0_ready;
    b1        = req1_valid && req1_ready;
    xfer_seen = out_valid && out_ready;
    chk("r0_ungranted", 32'(req0_ready && (grant != 2'b01)), 32'd0);
    chk("r1_ungranted", 32'(req1_ready && (grant != 2'b10)), 32'd0);
    chk("grant_legal", 32'(grant == 2'b11), 32'd0);
    chk("mux_op_grant", 32'(mux_op), 32'(grant == 2'b10));
    chk("ready_when_full", 32'((req0_ready || req1_ready) && out_valid && !out_ready), 32'd0);
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, prev_data);
    end
    if (xfer_seen) begin
      xfer_data = out_data;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_data", out_data, exp_q.pop_front());
      if (seq_en) begin
        chk("seq_data", out_data, ((k / 4) % 2 == 1) ? 32'd61 : 32'd34);
        k++;
      end
    end else if (seq_en && !out_valid && k >= 1 && k < 16) begin
      bubbles++;
    end
    if (!req0_valid || b0) wait0 = 0; else if (b1) wait0++;
    if (!req1_valid || b1) wait1 = 0; else if (b0) wait1++;
    chk("hold_bound0", 32'(wait0 <= MAX_HOLD), 32'd1);
    chk("hold_bound1", 32'(wait1 <= MAX_HOLD), 32'd1);
    if (b0) exp_q.push_back(req0_data);
    if (b1) exp_q.push_back(req1_data);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic wait_xfer(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = xfer_seen;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic got;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    out_ready = 1'b0;
    rem0 = 0; rem1 = 0; fix0 = 1'b1; fix1 = 1'b1;
    val0 = 32'd34; val1 = 32'd61;
    rnd_gap = 1'b0; ordy_mode = 1;
    seq_en = 1'b0; k = 0; bubbles = 0;
    clear_obs();

    // Power-on reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters continuously valid: req0 wins first tie, groups of MAX_HOLD.
    rem0 = 1000; rem1 = 1000;
    seq_en = 1'b1;
    for (int i = 0; i < 80 && k < 16; i++) step();
    chk("t3_sixteen_words", 32'(k), 32'd16);
    chk("t3_bubbles", 32'(bubbles), 32'd3);

    // Consumer stall: data held, owner not ready, count frozen.
    ordy_mode = 0;
    settle(4);
    chk("t4_stall_valid", 32'(out_valid), 32'd1);
    ordy_mode = 1;
    for (int i = 0; i < 80 && k < 32; i++) step();
    chk("t4_resume_words", 32'(k), 32'd32);
    seq_en = 1'b0;

    // Asynchronous reset mid-traffic, between clock edges.
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    rem0 = 0; rem1 = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    clear_obs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester: grant, ready, one-cycle output latency.
    rem0 = 1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      got = (grant == 2'b01);
    end
    chk("t2_grant", 32'(got), 32'd1);
    chk("t2_ready0", 32'(req0_ready), 32'd1);
    chk("t2_mux_op", 32'(mux_op), 32'd0);
    step();
    chk("t2_out_data", out_data, 32'd34);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    settle(5);

    // Tie from IDLE after req0 was last owner: req1 first.
    rem0 = 1; rem1 = 1;
    wait_xfer("t5a_timeout", 12);
    chk("t5a_first", xfer_data, 32'd61);
    wait_xfer("t5b_timeout", 12);
    chk("t5b_second", xfer_data, 32'd34);
    settle(5);
    // req1 alone, then tie: req0 first.
    rem1 = 1;
    wait_xfer("t5c_timeout", 12);
    chk("t5c_alone", xfer_data, 32'd61);
    settle(5);
    rem0 = 1; rem1 = 1;
    wait_xfer("t5d_timeout", 12);
    chk("t5d_first", xfer_data, 32'd34);
    wait_xfer("t5e_timeout", 12);
    chk("t5e_second", xfer_data, 32'd61);
    settle(5);

    // req1 alone for ten beats: no gaps, grant stays.
    fix1 = 1'b0;
    rem1 = 10;
    wait_xfer("t6_timeout", 12);
    for (int i = 1; i < 10; i++) begin
      step();
      chk("t6_no_gap", 32'(out_valid), 32'd1);
      chk("t6_grant", 32'(grant), 32'd2);
    end
    settle(5);

    // Randomized traffic with gaps and random consumer back-pressure.
    fix0 = 1'b0; fix1 = 1'b0;
    rnd_gap = 1'b1; ordy_mode = 2;
    rem0 = 1000000; rem1 = 1000000;
    settle(3000);

    // Drain: every accepted word delivered exactly once.
    rem0 = 0; rem1 = 0; ordy_mode = 1;
    settle(40);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
